// File: rtl/nasti_stream_writer_if.sv
// nasti_stream_writer_if: NASTI stream and NASTI memory channel bundles
interface nasti_stream_channel #(
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1,
    parameter int USER_WIDTH = 1
);
    logic                      t_valid;
    logic                      t_ready;
    logic [DATA_WIDTH-1:0]     t_data;
    logic                      t_last;
    logic [DATA_WIDTH/8-1:0]   t_strb;
    logic [DATA_WIDTH/8-1:0]   t_keep;
    logic [ID_WIDTH-1:0]       t_id;
    logic [DEST_WIDTH-1:0]     t_dest;
    logic [USER_WIDTH-1:0]     t_user;

    modport master (
        output t_valid, t_data, t_last, t_strb, t_keep, t_id, t_dest, t_user,
        input  t_ready
    );
    modport slave (
        input  t_valid, t_data, t_last, t_strb, t_keep, t_id, t_dest, t_user,
        output t_ready
    );
endinterface

interface nasti_channel #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 1,
    parameter int USER_WIDTH = 1
);
    logic [ID_WIDTH-1:0]       aw_id;
    logic [ADDR_WIDTH-1:0]     aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic                      aw_lock;
    logic [3:0]                aw_cache;
    logic [2:0]                aw_prot;
    logic [3:0]                aw_qos;
    logic [3:0]                aw_region;
    logic [USER_WIDTH-1:0]     aw_user;
    logic                      aw_valid;
    logic                      aw_ready;
    logic [DATA_WIDTH-1:0]     w_data;
    logic [DATA_WIDTH/8-1:0]   w_strb;
    logic                      w_last;
    logic [USER_WIDTH-1:0]     w_user;
    logic                      w_valid;
    logic                      w_ready;
    logic [ID_WIDTH-1:0]       b_id;
    logic [1:0]                b_resp;
    logic [USER_WIDTH-1:0]     b_user;
    logic                      b_valid;
    logic                      b_ready;
    logic [ID_WIDTH-1:0]       ar_id;
    logic [ADDR_WIDTH-1:0]     ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic                      ar_lock;
    logic [3:0]                ar_cache;
    logic [2:0]                ar_prot;
    logic [3:0]                ar_qos;
    logic [3:0]                ar_region;
    logic [USER_WIDTH-1:0]     ar_user;
    logic                      ar_valid;
    logic                      ar_ready;
    logic [ID_WIDTH-1:0]       r_id;
    logic [DATA_WIDTH-1:0]     r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic [USER_WIDTH-1:0]     r_user;
    logic                      r_valid;
    logic                      r_ready;

    modport master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );
    modport slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/nasti_stream_writer.sv
// nasti_stream_writer: writes a data stream to memory as 4 KiB-safe NASTI write bursts
module nasti_stream_writer #(
    parameter int ADDR_WIDTH       = 64,
    parameter int DATA_WIDTH       = 64,
    parameter int MAX_BURST_LENGTH = 8
) (
    input  logic                  aclk,
    input  logic                  areset,
    nasti_stream_channel.slave    src,
    nasti_channel.master          dst,
    input  logic [ADDR_WIDTH-1:0] w_dst,
    input  logic [ADDR_WIDTH-1:0] w_len,
    input  logic                  w_valid,
    output logic                  w_ready,
    output logic                  w_error
);
    localparam int ADDR_SHIFT = $clog2(DATA_WIDTH/8);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
    localparam logic [1:0] RESP = 2'd3;
    localparam logic [ADDR_WIDTH-1:0] ALIGN = ~ADDR_WIDTH'(DATA_WIDTH/8 - 1);

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] addr, len, cmd_len;
    logic [ADDR_WIDTH-1:0] rem_beats, bnd_beats, max_beats, min_rb, beats, bytes;
    logic [12:0]           bnd;
    logic [7:0]            cnt;
    logic                  hold, w_hs, last;

    assign cmd_len   = w_len & ALIGN;
    assign bnd       = (13'h1000 - {1'b0, addr[11:0]}) >> ADDR_SHIFT;
    assign rem_beats = len >> ADDR_SHIFT;
    assign bnd_beats = ADDR_WIDTH'(bnd);
    assign max_beats = ADDR_WIDTH'(MAX_BURST_LENGTH);
    assign min_rb    = rem_beats < bnd_beats ? rem_beats : bnd_beats;
    assign beats     = min_rb < max_beats ? min_rb : max_beats;
    assign bytes     = beats << ADDR_SHIFT;
    assign w_hs      = dst.w_valid & dst.w_ready;
    assign last      = cnt == dst.aw_len;
    assign w_ready   = state == IDLE && !hold;

    assign dst.aw_valid  = state == ADDR;
    assign dst.aw_addr   = addr;
    assign dst.aw_len    = 8'(beats - 1'b1);
    assign dst.aw_size   = 3'(ADDR_SHIFT);
    assign dst.aw_burst  = 2'b01;
    assign dst.aw_id     = '0;
    assign dst.aw_lock   = 1'b0;
    assign dst.aw_cache  = '0;
    assign dst.aw_prot   = '0;
    assign dst.aw_qos    = '0;
    assign dst.aw_region = '0;
    assign dst.aw_user   = '0;

    assign dst.w_valid = state == DATA && src.t_valid;
    assign src.t_ready = state == DATA && dst.w_ready;
    assign dst.w_data  = src.t_data;
    assign dst.w_strb  = '1;
    assign dst.w_last  = state == DATA && last;
    assign dst.w_user  = '0;
    assign dst.b_ready = state == RESP;

    assign dst.ar_valid  = 1'b0;
    assign dst.ar_id     = '0;
    assign dst.ar_addr   = '0;
    assign dst.ar_len    = '0;
    assign dst.ar_size   = '0;
    assign dst.ar_burst  = '0;
    assign dst.ar_lock   = 1'b0;
    assign dst.ar_cache  = '0;
    assign dst.ar_prot   = '0;
    assign dst.ar_qos    = '0;
    assign dst.ar_region = '0;
    assign dst.ar_user   = '0;
    assign dst.r_ready   = 1'b0;

    // command sequencing: accept, issue one burst at a time, wait for its response
    always_ff @(posedge aclk) begin
        if (areset) begin
            state   <= IDLE;
            addr    <= '0;
            len     <= '0;
            cnt     <= '0;
            hold    <= 1'b0;
            w_error <= 1'b0;
        end else begin
            hold <= 1'b0;
            if (w_valid && w_ready) begin
                addr    <= w_dst & ALIGN;
                len     <= cmd_len;
                cnt     <= '0;
                w_error <= 1'b0;
                hold    <= cmd_len == '0;
                state   <= cmd_len == '0 ? IDLE : ADDR;
            end
            if (state == ADDR && dst.aw_ready) begin
                state <= DATA;
                cnt   <= '0;
            end
            if (w_hs) begin
                cnt <= cnt + 8'd1;
                if (last) begin
                    state <= RESP;
                    addr  <= addr + bytes;
                    len   <= len - bytes;
                end
            end
            if (state == RESP && dst.b_valid) begin
                w_error <= w_error | (dst.b_resp != 2'b00);
                state   <= len != '0 ? ADDR : IDLE;
            end
        end
    end
endmodule

// File: tb/tb_nasti_stream_writer.sv
// tb_nasti_stream_writer: directed vectors against a stalling memory slave and counting stream source
module tb_nasti_stream_writer;
    typedef struct packed {
        logic [63:0]      dst;
        logic [63:0]      len;
        logic             stall;
        int               err_idx;
        int               nb;
        logic [3:0][63:0] a;
        logic [3:0][7:0]  l;
        logic             err;
    } vec_t;

    logic        aclk = 0, areset = 1;
    logic [63:0] w_dst = 0, w_len = 0;
    logic        w_valid = 0;
    logic        w_ready, w_error;

    int          tests = 0, fails = 0;
    bit          stall = 0, b_pending = 0, open = 0;
    int          err_idx = -1, bcnt = 0, viol = 0;
    logic [63:0] seq = 0;
    logic [63:0] aw_a[$];
    logic [7:0]  aw_l[$];
    logic [63:0] wd[$];
    bit          wl[$];
    vec_t        vt[9];

    nasti_stream_channel #(.DATA_WIDTH(64)) s();
    nasti_channel #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) d();

    nasti_stream_writer #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .MAX_BURST_LENGTH(8)) dut (
        .aclk(aclk), .areset(areset), .src(s), .dst(d),
        .w_dst(w_dst), .w_len(w_len), .w_valid(w_valid), .w_ready(w_ready), .w_error(w_error)
    );

    always #5 aclk = ~aclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [63:0] dst, len, input logic st, input int ei, nb,
                                input logic [63:0] a0, input logic [7:0] l0, input logic [63:0] a1,
                                input logic [7:0] l1, input logic [63:0] a2, input logic [7:0] l2,
                                input logic [63:0] a3, input logic [7:0] l3, input logic er);
        vec_t v;
        v.dst = dst; v.len = len; v.stall = st; v.err_idx = ei; v.nb = nb;
        v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3;
        v.l[0] = l0; v.l[1] = l1; v.l[2] = l2; v.l[3] = l3;
        v.err = er;
        return v;
    endfunction

    task automatic clear_logs();
        aw_a.delete(); aw_l.delete(); wd.delete(); wl.delete();
        bcnt = 0; b_pending = 0; open = 0;
    endtask

    // memory slave and stream source: drive after the edge, sample handshakes mid-cycle
    initial begin
        d.aw_ready = 0; d.w_ready = 0; d.b_valid = 0; d.b_resp = 0; d.b_id = 0; d.b_user = 0;
        d.ar_ready = 0; d.r_valid = 0; d.r_id = 0; d.r_data = 0; d.r_resp = 0; d.r_last = 0; d.r_user = 0;
        s.t_valid = 0; s.t_data = 0; s.t_last = 0; s.t_strb = 0; s.t_keep = 0; s.t_id = 0; s.t_dest = 0; s.t_user = 0;
        forever begin
            @(posedge aclk); #1;
            s.t_data   = seq;
            s.t_valid  = stall ? ($urandom_range(0, 4) != 0) : 1'b1;
            d.aw_ready = stall ? ($urandom_range(0, 4) != 0) : 1'b1;
            d.w_ready  = stall ? ($urandom_range(0, 4) != 0) : 1'b1;
            d.b_valid  = b_pending && (stall ? ($urandom_range(0, 4) != 0) : 1'b1);
            d.b_resp   = (bcnt == err_idx) ? 2'b10 : 2'b00;
            @(negedge aclk);
            if (!areset) begin
                if (s.t_valid && s.t_ready) seq++;
                if (d.aw_valid && d.aw_ready) begin
                    if (open) viol++;
                    open = 1;
                    aw_a.push_back(d.aw_addr);
                    aw_l.push_back(d.aw_len);
                end
                if (d.w_valid && d.w_ready) begin
                    wd.push_back(d.w_data);
                    wl.push_back(d.w_last);
                    if (d.w_last) b_pending = 1;
                end
                if (d.b_valid && d.b_ready) begin
                    b_pending = 0;
                    open = 0;
                    bcnt++;
                end
            end
        end
    end

    task automatic run_vec(input vec_t v, input string tag);
        logic [63:0] base, nbeats;
        int cyc, bad, k, cum;
        bit e;
        @(posedge aclk); #2;
        clear_logs();
        stall = v.stall; err_idx = v.err_idx; base = seq;
        w_dst = v.dst; w_len = v.len; w_valid = 1;
        @(negedge aclk);
        chk($sformatf("%s ready_idle", tag), w_ready, 1);
        @(posedge aclk); #2;
        w_valid = 0; w_dst = '1; w_len = '1;
        @(negedge aclk);
        chk($sformatf("%s ready_drop", tag), w_ready, 0);
        cyc = 0;
        while (!w_ready && cyc < 3000) begin
            @(negedge aclk);
            cyc++;
        end
        chk($sformatf("%s done_in_time", tag), cyc < 3000, 1);
        stall = 0; err_idx = -1;
        nbeats = (v.len & ~64'h7) >> 3;
        chk($sformatf("%s aw_count", tag), aw_a.size(), v.nb);
        for (int i = 0; i < v.nb && i < aw_a.size(); i++) begin
            chk($sformatf("%s aw_addr[%0d]", tag, i), aw_a[i], v.a[i]);
            chk($sformatf("%s aw_len[%0d]", tag, i), aw_l[i], v.l[i]);
        end
        chk($sformatf("%s w_beats", tag), wd.size(), nbeats);
        bad = 0;
        foreach (wd[j]) if (wd[j] !== base + j) bad++;
        chk($sformatf("%s data_order_errs", tag), bad, 0);
        bad = 0; k = 0; cum = v.l[0] + 1;
        foreach (wl[j]) begin
            e = (j + 1 == cum);
            if (wl[j] != e) bad++;
            if (e && k < 3) begin
                k++;
                cum += v.l[k] + 1;
            end
        end
        chk($sformatf("%s w_last_errs", tag), bad, 0);
        chk($sformatf("%s stream_beats", tag), seq - base, nbeats);
        chk($sformatf("%s w_error", tag), w_error, v.err);
        chk($sformatf("%s outstanding_viol", tag), viol, 0);
    endtask

    initial begin
        int cyc;
        vt[0] = mk(64'h1000, 64'h80, 0, -1, 2, 64'h1000, 7, 64'h1040, 7, 0, 0, 0, 0, 0);
        vt[1] = mk(64'h0FF0, 64'h40, 0, -1, 2, 64'h0FF0, 1, 64'h1000, 5, 0, 0, 0, 0, 0);
        vt[2] = mk(64'h2000, 64'h18, 0, -1, 1, 64'h2000, 2, 0, 0, 0, 0, 0, 0, 0);
        vt[3] = mk(64'h1003, 64'h47, 0, -1, 1, 64'h1000, 7, 0, 0, 0, 0, 0, 0, 0);
        vt[4] = mk(64'h1FF8, 64'h10, 0, -1, 2, 64'h1FF8, 0, 64'h2000, 0, 0, 0, 0, 0, 0);
        vt[5] = mk(64'h3000, 64'h100, 1, -1, 4, 64'h3000, 7, 64'h3040, 7, 64'h3080, 7, 64'h30C0, 7, 0);
        vt[6] = mk(64'h4000, 64'hC0, 0, 1, 3, 64'h4000, 7, 64'h4040, 7, 64'h4080, 7, 0, 0, 1);
        vt[7] = mk(64'h6000, 64'h40, 0, -1, 1, 64'h6000, 7, 0, 0, 0, 0, 0, 0, 0);
        vt[8] = mk(64'hFFFF_FFFF_FFFF_FFF8, 64'h10, 0, -1, 2, 64'hFFFF_FFFF_FFFF_FFF8, 0, 64'h0, 0, 0, 0, 0, 0, 0);

        repeat (2) @(posedge aclk);
        @(negedge aclk);
        chk("reset w_ready", w_ready, 1);
        chk("reset aw_valid", d.aw_valid, 0);
        chk("reset b_ready", d.b_ready, 0);
        chk("reset w_error", w_error, 0);
        chk("reset w_valid", d.w_valid, 0);
        chk("reset t_ready", s.t_ready, 0);
        @(posedge aclk); #2 areset = 0;

        for (int i = 0; i < 9; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        @(posedge aclk); #2;
        clear_logs();
        w_dst = 64'h7000; w_len = 64'h5; w_valid = 1;
        @(negedge aclk);
        chk("zero ready_idle", w_ready, 1);
        @(posedge aclk); #2 w_valid = 0;
        @(negedge aclk);
        chk("zero ready_low", w_ready, 0);
        chk("zero aw_valid_a", d.aw_valid, 0);
        @(negedge aclk);
        chk("zero ready_back", w_ready, 1);
        chk("zero aw_valid_b", d.aw_valid, 0);
        repeat (3) @(negedge aclk);
        chk("zero aw_count", aw_a.size(), 0);

        @(posedge aclk); #2;
        clear_logs();
        w_dst = 64'h5000; w_len = 64'h80; w_valid = 1;
        @(posedge aclk); #2 w_valid = 0;
        cyc = 0;
        while (wd.size() < 2 && cyc < 200) begin
            @(negedge aclk);
            cyc++;
        end
        chk("rst reached_data", cyc < 200, 1);
        @(posedge aclk); #2 areset = 1;
        @(posedge aclk); #2 areset = 0;
        @(negedge aclk);
        chk("rst w_ready", w_ready, 1);
        chk("rst aw_valid", d.aw_valid, 0);
        chk("rst w_valid", d.w_valid, 0);
        chk("rst t_ready", s.t_ready, 0);
        chk("rst b_ready", d.b_ready, 0);
        @(posedge aclk); #2 clear_logs();
        run_vec(vt[0], "after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/nasti_stream_writer.md
NASTI_STREAM_WRITER -- requirements
Module: nasti_stream_writer

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 64, giving the width of the memory address and command length.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 64, giving the data bus width in bits for both the stream and NASTI W channel.
REQ-003 The module SHALL have parameter MAX_BURST_LENGTH, default 8, giving the maximum number of beats per NASTI write burst.
REQ-004 The module SHALL have port aclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The module SHALL have port areset, input, 1 bit: reset, synchronous and active-high.
REQ-006 The module SHALL have port src, nasti_stream_channel.slave: the stream input, using t_valid, t_ready and t_data; t_last, t_strb, t_keep, t_id, t_dest and t_user are ignored.
REQ-007 The module SHALL have port dst, nasti_channel: a memory master using the AW, W and B channels.
REQ-008 The module SHALL tie dst AR outputs to constants with ar_valid=0, and SHALL drive r_ready=0.
REQ-009 The module SHALL have port w_dst, input, ADDR_WIDTH bits: the command destination byte address.
REQ-010 The module SHALL have port w_len, input, ADDR_WIDTH bits: the command length in bytes.
REQ-011 The module SHALL have port w_valid, input, 1 bit: command valid.
REQ-012 The module SHALL have port w_ready, output, 1 bit: the module is idle and accepts a command.
REQ-013 The module SHALL have port w_error, output, 1 bit: sticky flag, set when any B response of the current command is non-OKAY.

Function
REQ-014 A command SHALL be accepted on a cycle with w_valid=1 and w_ready=1; w_ready SHALL drop to 0 on the next cycle.
REQ-015 w_dst and w_len SHALL be truncated to DATA_WIDTH/8-byte alignment, with the low ADDR_SHIFT=clog2(DATA_WIDTH/8) bits cleared; w_error SHALL clear on acceptance.
REQ-016 The FSM SHALL have the states IDLE, ADDR, DATA and RESP.
REQ-017 In IDLE, w_ready SHALL be 1; an accepted command SHALL go to ADDR, or, if the truncated length is 0, SHALL stay in IDLE with w_ready=0 for exactly one cycle and issue no NASTI traffic.
REQ-018 In ADDR, the burst beat count SHALL be min(remaining beats, MAX_BURST_LENGTH, beats to the next 4 KiB boundary), where beats to boundary = (4096 - addr[11:0]) >> ADDR_SHIFT.
REQ-019 In ADDR, aw_valid SHALL be 1 with aw_addr = current address, aw_len = beats-1, aw_size = ADDR_SHIFT, aw_burst = INCR (01), and aw_id, aw_cache, aw_prot, aw_lock, aw_qos, aw_region and aw_user all 0.
REQ-020 aw_valid and all AW fields SHALL be held stable until aw_ready; on the handshake the FSM SHALL go to DATA.
REQ-021 In DATA, w_valid SHALL equal src.t_valid, src.t_ready SHALL equal dst.w_ready, w_data SHALL equal t_data, w_strb SHALL be all ones, and w_user SHALL be 0.
REQ-022 Outside DATA, w_valid and src.t_ready SHALL be 0.
REQ-023 w_last SHALL be 1 only on the final beat of the burst, using a beat counter with the same width as aw_len.
REQ-024 On the w_last handshake, the FSM SHALL go to RESP, and remaining length and address SHALL update by beats<<ADDR_SHIFT.
REQ-025 In RESP, b_ready SHALL be 1; on b_valid, w_error SHALL be set if b_resp != 00.
REQ-026 After the B handshake, the FSM SHALL go to ADDR if the remaining length is nonzero, else to IDLE with w_ready=1 on the following cycle.
REQ-027 At most one burst SHALL be outstanding; AW for burst N+1 SHALL NOT issue before B of burst N.
REQ-028 An error SHALL NOT abort the command; all bursts SHALL still be written.
REQ-029 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH; no overflow detection SHALL be performed.
REQ-030 w_valid/w_dst/w_len changes while w_ready=0 SHALL be ignored.
REQ-031 Stream backpressure SHALL be lossless: no stream beat is consumed without a matching W handshake.

Reset
REQ-032 While areset=1 at a rising edge, the FSM SHALL enter IDLE with w_ready=1, aw_valid=0, b_ready=0, w_error=0 and counters at 0; w_valid and t_ready SHALL follow as 0 because the state is not DATA.
REQ-033 Reset mid-burst SHALL abandon the command immediately; no pending AW, W or B state SHALL persist.

Verification
REQ-034 A bench SHALL cover: w_dst=0x1000, w_len=0x80, DATA_WIDTH=64 -> two AW bursts, at 0x1000 then 0x1040, each aw_len=7; 16 W beats with w_last on beats 8 and 16; w_ready returns, w_error=0.
REQ-035 A bench SHALL cover: w_dst=0x0FF0, w_len=0x40 -> bursts of 2 beats at 0x0FF0 and 6 beats at 0x1000, with no 4 KiB crossing.
REQ-036 A bench SHALL cover: w_len=0x18 -> single AW with aw_len=2; w_len=0x5 -> truncated to 0, w_ready low for one cycle, and no AW.
REQ-037 A bench SHALL cover: random t_valid and w_ready/aw_ready/b_valid stalls, 20% duty, 256-byte command -> data written equals the stream order exactly, with no dropped or duplicated beats.
REQ-038 A bench SHALL cover: the second of 3 bursts returning b_resp=10 (SLVERR) -> the third burst is still issued, and w_error=1 when w_ready rises.
REQ-039 A bench SHALL cover: areset asserted during DATA beat 3 -> the next cycle shows w_ready=1, aw_valid=0, w_valid=0, t_ready=0; a new command then completes normally.
